// File: rtl/riscv_muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_muldiv_pkg                                                     |
// | Shared op codes, FSM states and operand-sign helpers for muldiv.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package riscv_muldiv_pkg;

   localparam logic [2:0] FUNCT3_MUL    = 3'b000;
   localparam logic [2:0] FUNCT3_MULH   = 3'b001;
   localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
   localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
   localparam logic [2:0] FUNCT3_DIV    = 3'b100;
   localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
   localparam logic [2:0] FUNCT3_REM    = 3'b110;
   localparam logic [2:0] FUNCT3_REMU   = 3'b111;

   typedef enum logic [2:0] {
      OP_MUL    = FUNCT3_MUL,
      OP_MULH   = FUNCT3_MULH,
      OP_MULHSU = FUNCT3_MULHSU,
      OP_MULHU  = FUNCT3_MULHU,
      OP_DIV    = FUNCT3_DIV,
      OP_DIVU   = FUNCT3_DIVU,
      OP_REM    = FUNCT3_REM,
      OP_REMU   = FUNCT3_REMU
   } muldiv_op_e;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MUL     = 3'd1,
      S_DIV     = 3'd2,
      S_SPECIAL = 3'd3,
      S_FIX     = 3'd4,
      S_DONE    = 3'd5
   } muldiv_state_e;

   function automatic logic op_signed_a(input logic [2:0] f);
      return (f == FUNCT3_MULH) || (f == FUNCT3_MULHSU) ||
             (f == FUNCT3_DIV)  || (f == FUNCT3_REM);
   endfunction

   function automatic logic op_signed_b(input logic [2:0] f);
      return (f == FUNCT3_MULH) || (f == FUNCT3_DIV) || (f == FUNCT3_REM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/flopenr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flopenr                                                              |
// | Enabled register with asynchronous active-high reset to zero.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module flopenr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     o_q <= '0;
      else if (i_en) o_q <= i_d;
   end

endmodule
`default_nettype wire

// File: rtl/riscv_muldiv_signfix.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_muldiv_signfix                                                 |
// | Applies result signs to the unsigned magnitudes and selects the word.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module riscv_muldiv_signfix
   import riscv_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  muldiv_op_e          i_op,
   input  logic                i_neg_q,
   input  logic                i_neg_r,
   input  logic [2*XLEN-1:0]   i_prod,
   input  logic [XLEN-1:0]     i_quo,
   input  logic [XLEN-1:0]     i_rem,
   output logic [XLEN-1:0]     o_fixed
);

   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;

   // Product is negated at full width so the high half carries the borrow.
   assign w_prod = i_neg_q ? -i_prod : i_prod;
   assign w_quo  = i_neg_q ? -i_quo  : i_quo;
   assign w_rem  = i_neg_r ? -i_rem  : i_rem;

   always_comb begin
      o_fixed = '0;
      case (i_op)
         OP_MUL:                       o_fixed = w_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: o_fixed = w_prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              o_fixed = w_quo;
         OP_REM, OP_REMU:              o_fixed = w_rem;
         default:                      o_fixed = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/riscv_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_muldiv                                                         |
// | Iterative RV32M/RV64M multiply/divide with start/busy/done handshake.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module riscv_muldiv
   import riscv_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int                 c_cnt_w   = $clog2(XLEN) + 1;
   localparam logic [c_cnt_w-1:0] c_iters   = c_cnt_w'(XLEN);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
   localparam logic [XLEN-1:0]    c_min     = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_e       r_state, w_next, w_start_state;
   muldiv_op_e          r_op;
   logic                r_sa, r_sb;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [XLEN-1:0]     r_opnd, r_spec;
   logic [2*XLEN-1:0]   r_prod;
   logic [XLEN:0]       r_rem;

   logic                w_accept, w_sa, w_sb, w_b_zero, w_ovf, w_special, w_ge, w_load;
   logic [XLEN-1:0]     w_mag_a, w_mag_b, w_spec_val, w_fixed, w_result_d;
   logic [XLEN:0]       w_mul_sum;
   logic [XLEN+1:0]     w_trial, w_diff;

   assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done     = (r_state == S_DONE);
   assign w_accept = start && !flush && !busy;

   assign w_sa    = op_signed_a(funct3) & a[XLEN-1];
   assign w_sb    = op_signed_b(funct3) & b[XLEN-1];
   assign w_mag_a = w_sa ? -a : a;
   assign w_mag_b = w_sb ? -b : b;

   // Degenerate divides are resolved at accept time and skip the iteration.
   assign w_b_zero   = (b == '0);
   assign w_ovf      = !funct3[0] && (a == c_min) && (&b);
   assign w_special  = funct3[2] && (w_b_zero || w_ovf);
   assign w_spec_val = w_b_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : c_min);

   always_comb begin
      w_start_state = S_MUL;
      if (w_special)      w_start_state = S_SPECIAL;
      else if (funct3[2]) w_start_state = S_DIV;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (start) w_next = w_start_state;
         S_MUL, S_DIV: if (r_cnt == c_iters) w_next = S_FIX;
         S_SPECIAL:    w_next = S_DONE;
         S_FIX:        w_next = S_DONE;
         S_DONE:       w_next = start ? w_start_state : S_IDLE;
         default:      w_next = S_IDLE;
      endcase
      if (flush) w_next = S_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Multiplier in the low half shifts out LSB-first as the product fills in from the top.
   assign w_mul_sum = {1'b0, r_prod[2*XLEN-1:XLEN]} + ({(XLEN+1){r_prod[0]}} & {1'b0, r_opnd});
   assign w_trial   = {r_rem, r_prod[XLEN-1]};
   assign w_diff    = w_trial - {2'b00, r_opnd};
   assign w_ge      = !w_diff[XLEN+1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op   <= OP_MUL;
         r_sa   <= 1'b0;
         r_sb   <= 1'b0;
         r_cnt  <= '0;
         r_opnd <= '0;
         r_spec <= '0;
         r_prod <= '0;
         r_rem  <= '0;
      end else if (w_accept) begin
         r_op   <= muldiv_op_e'(funct3);
         r_sa   <= w_sa;
         r_sb   <= w_sb;
         r_cnt  <= '0;
         r_opnd <= funct3[2] ? w_mag_b : w_mag_a;
         r_spec <= w_spec_val;
         r_prod <= {{XLEN{1'b0}}, (funct3[2] ? w_mag_a : w_mag_b)};
         r_rem  <= '0;
      end else if ((r_state == S_MUL) && (r_cnt != c_iters)) begin
         r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
         r_cnt  <= r_cnt + c_cnt_one;
      end else if ((r_state == S_DIV) && (r_cnt != c_iters)) begin
         r_prod[XLEN-1:0] <= {r_prod[XLEN-2:0], w_ge};
         r_rem            <= w_ge ? w_diff[XLEN:0] : w_trial[XLEN:0];
         r_cnt            <= r_cnt + c_cnt_one;
      end
   end

   riscv_muldiv_signfix #(.XLEN(XLEN)) u_signfix (
      .i_op    (r_op),
      .i_neg_q (r_sa ^ r_sb),
      .i_neg_r (r_sa),
      .i_prod  (r_prod),
      .i_quo   (r_prod[XLEN-1:0]),
      .i_rem   (r_rem[XLEN-1:0]),
      .o_fixed (w_fixed)
   );

   assign w_load     = !flush && ((r_state == S_FIX) || (r_state == S_SPECIAL));
   assign w_result_d = (r_state == S_SPECIAL) ? r_spec : w_fixed;

   flopenr #(.WIDTH(XLEN)) u_result (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_load),
      .i_d   (w_result_d),
      .o_q   (result)
   );

endmodule
`default_nettype wire
